i2c_target_rx: RTL and testbench

//  Oversampled I2C target (slave) receiver, downstream of the i2c master FSM on the SDA/SCL bus.

---
 rtl/i2c_target_rx.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Oversampled I2C target receiver: START/STOP detect, address match with ACK, MSB-first byte strobes.
// Optional feature macro: GENERAL_CALL_EN (address 7'h00 also matches; adds gen_call output).
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_rw,
  output logic       addr_match,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
`ifdef GENERAL_CALL_EN
  ,
  output logic       gen_call
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  // NOTE: synchronisers preset to 1 so leaving reset on an idle bus produces no false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   =  scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s &  scl_prev_q;
  assign start_cond =  scl_s &  sda_prev_q & ~sda_s;
  assign stop_cond  =  scl_s & ~sda_prev_q &  sda_s;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_rw_q, rx_rw_d;
  logic       addr_match_q, addr_match_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] byte_in;
  logic       addr_hit;
`ifdef GENERAL_CALL_EN
  logic       gc_q, gc_d;
  assign addr_hit = (shift_q == TARGET_ADDR) || (shift_q == 7'h00);
`else
  assign addr_hit = (shift_q == TARGET_ADDR);
`endif

  // The bit being sampled now completes the byte together with the seven already shifted.
  assign byte_in = {shift_q, sda_s};

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_rw_d      = rx_rw_q;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    sda_oe_d     = sda_oe_q;
`ifdef GENERAL_CALL_EN
    gc_d         = gc_q;
`endif
    if (start_cond) begin
      state_d      = ADDR;
      cnt_d        = 3'd0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      start_d      = 1'b1;
`ifdef GENERAL_CALL_EN
      gc_d         = 1'b0;
`endif
    end else if (stop_cond) begin
      state_d      = IDLE;
      cnt_d        = 3'd0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      stop_d       = 1'b1;
`ifdef GENERAL_CALL_EN
      gc_d         = 1'b0;
`endif
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = byte_in[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (addr_hit) begin
              rx_rw_d = sda_s;
`ifdef GENERAL_CALL_EN
              gc_d    = (shift_q == 7'h00);
`endif
              state_d = ACK_A;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First SCL fall starts the ACK bit, the second one ends it.
        ACK_A, ACK_D: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d     = 1'b1;
            addr_match_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = DATA;
          end
        end
        DATA: if (scl_rise) begin
          shift_d = byte_in[6:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            state_d    = ACK_D;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 7'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_rw_q      <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
`ifdef GENERAL_CALL_EN
      gc_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_rw_q      <= rx_rw_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      sda_oe_q     <= sda_oe_d;
`ifdef GENERAL_CALL_EN
      gc_q         <= gc_d;
`endif
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_rw      = rx_rw_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;
  assign start_det  = start_q;
  assign stop_det   = stop_q;
`ifdef GENERAL_CALL_EN
  assign gen_call   = gc_q & addr_match_q;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: bus-level master model, transaction table, rx scoreboard.
module tb_i2c_target_rx;

  localparam int Q = 8;  // clk cycles per quarter SCL period
`ifdef GENERAL_CALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, rx_rw, addr_match, busy, start_det, stop_det;
  logic [7:0] rx_data;
`ifdef GENERAL_CALL_EN
  logic       gen_call;
`endif

  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_drv),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_rw      (rx_rw),
    .addr_match (addr_match),
    .busy       (busy),
    .start_det  (start_det),
    .stop_det   (stop_det)
`ifdef GENERAL_CALL_EN
    ,
    .gen_call   (gen_call)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_start = 0, n_stop = 0, n_oe = 0, n_valid = 0;
  logic oe_prev = 1'b0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: event counters and rx scoreboard, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe && !oe_prev) n_oe++;
    oe_prev = sda_oe;
    if (rx_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_valid_unexpected: got rx_data %0h, expected no strobe", rx_data);
      end else begin
        check("rx_data_scoreboard", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  task automatic i2c_bit(input logic b);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2 * Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    ack = ~sda_bus;
    wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              nbytes;
    logic [2:0][7:0] data;
    logic            match;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] a, input logic rw, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic m);
    vec_t v;
    v.addr = a; v.rw = rw; v.nbytes = n;
    v.data[0] = b0; v.data[1] = b1; v.data[2] = b2;
    v.match = m;
    return v;
  endfunction

  logic [7:0] last_data = 8'h00;
  logic       last_rw = 1'b0;

  task automatic run_vec(input vec_t v, input int idx);
    int   s0, p0, o0, r0;
    logic ack;
    s0 = n_start; p0 = n_stop; o0 = n_oe; r0 = n_valid;
    i2c_start();
    check($sformatf("v%0d_busy_after_start", idx), busy, 1);
    i2c_byte({v.addr, v.rw}, ack);
    check($sformatf("v%0d_addr_ack", idx), ack, v.match);
    check($sformatf("v%0d_addr_match", idx), addr_match, v.match);
    for (int i = 0; i < v.nbytes; i++) begin
      if (v.match) sb_q.push_back(v.data[i]);
      i2c_byte(v.data[i], ack);
      check($sformatf("v%0d_data%0d_ack", idx, i), ack, v.match);
    end
    if (v.match) begin
      last_rw = v.rw;
      if (v.nbytes > 0) last_data = v.data[v.nbytes-1];
    end
    i2c_stop();
    wait_clk(Q);
    check($sformatf("v%0d_busy_after_stop", idx), busy, 0);
    check($sformatf("v%0d_match_after_stop", idx), addr_match, 0);
    check($sformatf("v%0d_start_pulses", idx), n_start - s0, 1);
    check($sformatf("v%0d_stop_pulses", idx), n_stop - p0, 1);
    check($sformatf("v%0d_ack_pulses", idx), n_oe - o0, v.match ? v.nbytes + 1 : 0);
    check($sformatf("v%0d_rx_valid_pulses", idx), n_valid - r0, v.match ? v.nbytes : 0);
    check($sformatf("v%0d_scoreboard_empty", idx), sb_q.size(), 0);
    check($sformatf("v%0d_rx_data", idx), rx_data, last_data);
    check($sformatf("v%0d_rx_rw", idx), rx_rw, last_rw);
  endtask

  vec_t vecs[7];

  initial begin
    logic ack;
    int   s0, r0, tmo;

    vecs[0] = mk(7'h32, 1'b0, 1, 8'h0A, 8'h00, 8'h00, 1'b1);
    vecs[1] = mk(7'h32, 1'b1, 1, 8'hA5, 8'h00, 8'h00, 1'b1);
    vecs[2] = mk(7'h33, 1'b0, 1, 8'hFF, 8'h00, 8'h00, 1'b0);
    vecs[3] = mk(7'h32, 1'b0, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    vecs[4] = mk(7'h00, 1'b0, 1, 8'h77, 8'h00, 8'h00, GC);
    vecs[5] = mk(7'h19, 1'b0, 2, 8'hAA, 8'h55, 8'h00, 1'b0);
    vecs[6] = mk(7'h32, 1'b0, 2, 8'h00, 8'hFF, 8'h00, 1'b1);

    // Reset state
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_rw", rx_rw, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_busy", busy, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    reset = 1'b1;
    wait_clk(Q);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Partial byte cut short by a repeated START, then a full byte
    s0 = n_start; r0 = n_valid;
    i2c_start();
    i2c_byte({7'h32, 1'b0}, ack);
    check("rs_addr_ack", ack, 1);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1);
    i2c_start();
    check("rs_match_dropped", addr_match, 0);
    check("rs_busy", busy, 1);
    i2c_byte({7'h32, 1'b0}, ack);
    check("rs_addr2_ack", ack, 1);
    sb_q.push_back(8'h5C);
    i2c_byte(8'h5C, ack);
    check("rs_data_ack", ack, 1);
    i2c_stop();
    wait_clk(Q);
    check("rs_start_pulses", n_start - s0, 2);
    check("rs_valid_pulses", n_valid - r0, 1);
    check("rs_rx_data", rx_data, 8'h5C);
    check("rs_scoreboard_empty", sb_q.size(), 0);

    // Reset asserted while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(((8'h64 >> i) & 8'h01) != 0);
    sda_drv = 1'b1;
    tmo = 0;
    while (!sda_oe && tmo < 4 * Q) begin
      wait_clk(1);
      tmo++;
    end
    check("mr_ack_seen", sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_sda_oe", sda_oe, 0);
    check("mr_busy", busy, 0);
    check("mr_rx_data", rx_data, 0);
    check("mr_addr_match", addr_match, 0);
    check("mr_rx_valid", rx_valid, 0);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(Q);
    check("mr_idle_busy", busy, 0);
    last_data = 8'h00;
    last_rw = 1'b0;
    run_vec(vecs[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
